// File: rtl/sccb_target_if.sv
// Register-bus side of the SCCB target: pointer, write/read strobes and busy flag.
// The target drives through the master modport; the register file uses slave.
interface sccb_target_if;
   logic [15:0] reg_addr;
   logic        reg_we;
   logic [7:0]  reg_wdata;
   logic        reg_re;
   logic [7:0]  reg_rdata;
   logic        busy;

   modport master (output reg_addr, reg_we, reg_wdata, reg_re, busy, input reg_rdata);
   modport slave  (input reg_addr, reg_we, reg_wdata, reg_re, busy, output reg_rdata);
endinterface

// File: rtl/sccb_target.sv
// SCCB/I2C target for 16-bit register address / 8-bit data transfers, bridged to
// a synchronous register bus. Oversamples scl/sda with clk.
//
// state     | meaning
// IDLE      | bus free or after STOP
// DEV       | shifting in device address + R/W
// DEV_ACK   | acking device address
// AHI       | shifting in register address [15:8]
// AHI_ACK   | acking address high byte
// ALO       | shifting in register address [7:0]
// ALO_ACK   | acking address low byte
// WDAT      | shifting in write data
// WDAT_ACK  | acking write data
// RDAT      | shifting out read data
// RDAT_MACK | waiting for the initiator's ACK/NACK
// IGNORE    | not addressed or read NACKed; wait for START/STOP
module sccb_target #(
   parameter logic [7:0] DevAddr    = 8'h78,
   parameter int         SyncStages = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          scl,
   inout  wire           sda,
   sccb_target_if.master rbus
);

   typedef enum logic [3:0] {
      IDLE, DEV, DEV_ACK, AHI, AHI_ACK, ALO, ALO_ACK,
      WDAT, WDAT_ACK, RDAT, RDAT_MACK, IGNORE
   } state_t;

   state_t                state;
   logic [SyncStages-1:0] scl_sync;
   logic [SyncStages-1:0] sda_sync;
   logic                  scl_q;
   logic                  sda_q;
   logic                  scl_s;
   logic                  sda_s;
   logic                  scl_rise;
   logic                  scl_fall;
   logic                  start;
   logic                  stop;
   logic [2:0]            bit_cnt;
   logic [7:0]            shreg;
   logic [7:0]            rx_byte;
   logic                  rw;
   logic                  ack_on;
   logic                  sda_low;

   assign sda = sda_low ? 1'b0 : 1'bz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SyncStages-2:0], scl};
         sda_sync <= {sda_sync[SyncStages-2:0], sda};
         scl_q    <= scl_s;
         sda_q    <= sda_s;
      end
   end

   assign scl_s    = scl_sync[SyncStages-1];
   assign sda_s    = sda_sync[SyncStages-1];
   assign scl_rise = scl_s & ~scl_q;
   assign scl_fall = ~scl_s & scl_q;
   assign start    = scl_s & scl_q & sda_q & ~sda_s;
   assign stop     = scl_s & scl_q & ~sda_q & sda_s;
   assign rx_byte  = {shreg[6:0], sda_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         bit_cnt        <= '0;
         shreg          <= '0;
         rw             <= 1'b0;
         ack_on         <= 1'b0;
         sda_low        <= 1'b0;
         rbus.reg_addr  <= '0;
         rbus.reg_we    <= 1'b0;
         rbus.reg_wdata <= '0;
         rbus.reg_re    <= 1'b0;
         rbus.busy      <= 1'b0;
      end else begin
         rbus.reg_we <= 1'b0;
         rbus.reg_re <= 1'b0;
         // Post-strobe housekeeping: pointer bump after a write, data capture after a read request.
         if (rbus.reg_we) rbus.reg_addr <= rbus.reg_addr + 16'd1;
         if (rbus.reg_re) shreg <= rbus.reg_rdata;

         if (start) begin
            state   <= DEV;
            bit_cnt <= '0;
            ack_on  <= 1'b0;
            sda_low <= 1'b0;
         end else if (stop) begin
            state     <= IDLE;
            ack_on    <= 1'b0;
            sda_low   <= 1'b0;
            rbus.busy <= 1'b0;
         end else begin
            case (state)
               DEV, AHI, ALO, WDAT: begin
                  if (scl_rise) begin
                     shreg   <= rx_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (state == DEV) begin
                           if (rx_byte[7:1] == DevAddr[7:1]) begin
                              state       <= DEV_ACK;
                              rbus.busy   <= 1'b1;
                              rw          <= rx_byte[0];
                              rbus.reg_re <= rx_byte[0];
                           end else begin
                              state     <= IGNORE;
                              rbus.busy <= 1'b0;
                           end
                        end else if (state == AHI) begin
                           rbus.reg_addr[15:8] <= rx_byte;
                           state               <= AHI_ACK;
                        end else if (state == ALO) begin
                           rbus.reg_addr[7:0] <= rx_byte;
                           state              <= ALO_ACK;
                        end else begin
                           rbus.reg_we    <= 1'b1;
                           rbus.reg_wdata <= rx_byte;
                           state          <= WDAT_ACK;
                        end
                     end
                  end
               end
               DEV_ACK, AHI_ACK, ALO_ACK, WDAT_ACK: begin
                  // First fall starts the ACK low, second fall ends the 9th clock.
                  if (scl_fall) begin
                     if (!ack_on) begin
                        ack_on  <= 1'b1;
                        sda_low <= 1'b1;
                     end else begin
                        ack_on  <= 1'b0;
                        sda_low <= 1'b0;
                        bit_cnt <= '0;
                        if (state == DEV_ACK) begin
                           if (rw) begin
                              state   <= RDAT;
                              sda_low <= ~shreg[7];
                              shreg   <= {shreg[6:0], 1'b0};
                              bit_cnt <= 3'd1;
                           end else begin
                              state <= AHI;
                           end
                        end else if (state == AHI_ACK) begin
                           state <= ALO;
                        end else begin
                           state <= WDAT;
                        end
                     end
                  end
               end
               RDAT: begin
                  if (scl_fall) begin
                     if (bit_cnt == 3'd0) begin
                        sda_low <= 1'b0;
                        state   <= RDAT_MACK;
                     end else begin
                        sda_low <= ~shreg[7];
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end
               RDAT_MACK: begin
                  if (scl_rise && !ack_on) begin
                     if (!sda_s) begin
                        ack_on        <= 1'b1;
                        rbus.reg_addr <= rbus.reg_addr + 16'd1;
                        rbus.reg_re   <= 1'b1;
                     end else begin
                        state     <= IGNORE;
                        rbus.busy <= 1'b0;
                     end
                  end else if (scl_fall && ack_on) begin
                     ack_on  <= 1'b0;
                     state   <= RDAT;
                     sda_low <= ~shreg[7];
                     shreg   <= {shreg[6:0], 1'b0};
                     bit_cnt <= 3'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: bit-banged SCCB initiator plus a small register-bus model.
module tb_sccb_target;
   localparam int Q = 50;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic scl = 1'b1;
   logic m_sda_low = 1'b0;
   wire  sda;

   int vectors = 0;
   int miscompares = 0;
   int tgt_low_cnt = 0;
   int both_cnt = 0;
   logic busy_seen = 1'b0;
   logic [23:0] we_q[$];
   logic [15:0] re_q[$];

   logic [3:0] acks;
   logic       a;
   logic [7:0] rb0, rb1;

   sccb_target_if rbus ();

   pullup (sda);
   assign sda = m_sda_low ? 1'b0 : 1'bz;

   assign rbus.reg_rdata = (rbus.reg_addr == 16'h300A) ? 8'h56 :
                           (rbus.reg_addr == 16'h300B) ? 8'hA5 : 8'h00;

   sccb_target #(.DevAddr(8'h78), .SyncStages(2)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .scl  (scl),
      .sda  (sda),
      .rbus (rbus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rbus.reg_we) we_q.push_back({rbus.reg_addr, rbus.reg_wdata});
      if (rbus.reg_re) re_q.push_back(rbus.reg_addr);
      if (rbus.reg_we && rbus.reg_re) both_cnt++;
      if (sda === 1'b0 && !m_sda_low) tgt_low_cnt++;
      if (rbus.busy === 1'b1) busy_seen = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] we_at(input int i);
      return (i < we_q.size()) ? {8'h00, we_q[i]} : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] re_at(input int i);
      return (i < re_q.size()) ? {16'h0000, re_q[i]} : 32'hFFFF_FFFF;
   endfunction

   task automatic start_cond();
      if (scl == 1'b0) begin
         m_sda_low = 1'b0; #Q; scl = 1'b1; #Q;
      end
      m_sda_low = 1'b1; #Q; scl = 1'b0; #Q;
   endtask

   task automatic stop_cond();
      m_sda_low = 1'b1; #Q; scl = 1'b1; #Q; m_sda_low = 1'b0; #Q;
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i >= 8 - n; i--) begin
         m_sda_low = ~b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
      end
   endtask

   task automatic write_byte(input logic [7:0] b, output logic nack);
      send_bits(b, 8);
      m_sda_low = 1'b0; #Q; scl = 1'b1; #Q;
      nack = (sda !== 1'b0);
      #Q; scl = 1'b0; #Q;
   endtask

   task automatic read_byte(input logic ack_it, output logic [7:0] b);
      m_sda_low = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         #Q; scl = 1'b1; #Q; b[i] = (sda === 1'b1); #Q; scl = 1'b0; #Q;
      end
      m_sda_low = ack_it; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
      m_sda_low = 1'b0;
   endtask

   initial begin
      #23;
      chk("rst_addr", rbus.reg_addr, 16'h0000);
      chk("rst_we", rbus.reg_we, 1'b0);
      chk("rst_re", rbus.reg_re, 1'b0);
      chk("rst_wdata", rbus.reg_wdata, 8'h00);
      chk("rst_busy", rbus.busy, 1'b0);
      chk("rst_sda", sda, 1'b1);
      rst_n = 1'b1;
      #(2*Q);

      // single write 0x82 to 0x3008
      we_q.delete();
      start_cond();
      write_byte(8'h78, acks[3]);
      write_byte(8'h30, acks[2]);
      write_byte(8'h08, acks[1]);
      write_byte(8'h82, acks[0]);
      chk("t1_busy_mid", rbus.busy, 1'b1);
      stop_cond();
      chk("t1_acks", acks, 4'b0000);
      chk("t1_we_cnt", we_q.size(), 1);
      chk("t1_we0", we_at(0), 24'h3008_82);
      chk("t1_addr_after", rbus.reg_addr, 16'h3009);
      chk("t1_busy_after", rbus.busy, 1'b0);

      // wrong device address
      we_q.delete();
      tgt_low_cnt = 0;
      busy_seen = 1'b0;
      start_cond();
      write_byte(8'h42, acks[2]);
      write_byte(8'h30, acks[1]);
      write_byte(8'h08, acks[0]);
      stop_cond();
      chk("t2_acks", acks[2:0], 3'b111);
      chk("t2_tgt_low", tgt_low_cnt, 0);
      chk("t2_we_cnt", we_q.size(), 0);
      chk("t2_busy_seen", busy_seen, 1'b0);

      // burst write at 0x4300
      we_q.delete();
      start_cond();
      write_byte(8'h78, a);
      write_byte(8'h43, a);
      write_byte(8'h00, a);
      write_byte(8'h11, a);
      write_byte(8'h22, a);
      write_byte(8'h33, a);
      stop_cond();
      chk("t3_we_cnt", we_q.size(), 3);
      chk("t3_we0", we_at(0), 24'h4300_11);
      chk("t3_we1", we_at(1), 24'h4301_22);
      chk("t3_we2", we_at(2), 24'h4302_33);
      chk("t3_addr_after", rbus.reg_addr, 16'h4303);

      // random read from 0x300A with repeated START
      we_q.delete();
      re_q.delete();
      start_cond();
      write_byte(8'h78, acks[3]);
      write_byte(8'h30, acks[2]);
      write_byte(8'h0A, acks[1]);
      start_cond();
      write_byte(8'h79, acks[0]);
      read_byte(1'b1, rb0);
      read_byte(1'b0, rb1);
      #Q;
      chk("t4_sda_released", sda, 1'b1);
      chk("t4_busy_nack", rbus.busy, 1'b0);
      stop_cond();
      chk("t4_acks", acks, 4'b0000);
      chk("t4_rd0", rb0, 8'h56);
      chk("t4_rd1", rb1, 8'hA5);
      chk("t4_re_cnt", re_q.size(), 2);
      chk("t4_re0", re_at(0), 16'h300A);
      chk("t4_re1", re_at(1), 16'h300B);
      chk("t4_we_cnt", we_q.size(), 0);

      // STOP after 5 data bits, then a full write
      we_q.delete();
      start_cond();
      write_byte(8'h78, a);
      write_byte(8'h12, a);
      write_byte(8'h34, a);
      send_bits(8'hA5, 5);
      stop_cond();
      chk("t5_we_cnt", we_q.size(), 0);
      chk("t5_addr", rbus.reg_addr, 16'h1234);
      chk("t5_busy", rbus.busy, 1'b0);
      start_cond();
      write_byte(8'h78, acks[3]);
      write_byte(8'h12, acks[2]);
      write_byte(8'h34, acks[1]);
      write_byte(8'h5A, acks[0]);
      stop_cond();
      chk("t5_acks2", acks, 4'b0000);
      chk("t5_we0", we_at(0), 24'h1234_5A);

      // async reset while target holds ACK low
      start_cond();
      send_bits(8'h78, 8);
      m_sda_low = 1'b0; #Q; scl = 1'b1; #Q;
      chk("t6_ack_low", sda, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("t6_sda_rel", sda, 1'b1);
      chk("t6_addr", rbus.reg_addr, 16'h0000);
      chk("t6_wdata", rbus.reg_wdata, 8'h00);
      chk("t6_we", rbus.reg_we, 1'b0);
      chk("t6_re", rbus.reg_re, 1'b0);
      chk("t6_busy", rbus.busy, 1'b0);
      #Q; scl = 1'b0; #Q; scl = 1'b1; #Q;
      rst_n = 1'b1;
      #(2*Q);
      start_cond();
      write_byte(8'h78, a);
      stop_cond();
      chk("t6_ack_after", a, 1'b0);
      chk("no_we_re_overlap", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
- SCCB/I2C target (responder) that accepts the 16-bit-register-address, 8-bit-data transactions the camera-init master issues.
- Exposes those transactions as a simple synchronous register-bus write/read port.
- Used as the camera-side model in init-sequence simulation.
- Also usable on hardware as a configuration slave for downstream blocks, e.g. HDMI timing registers.

Parameters:
- DevAddr, 8'h78, 8-bit write-form device address; bit 0 is ignored on compare, only bits [7:1] are matched.
- SyncStages, 2, synchronizer flops on scl and sda inputs; minimum 2.

Ports:
- clk  in  1  system clock; must be ≥ 8× the SCL bit rate.
- rst_n  in  1  reset, asynchronous, active-low.
- scl  in  1  bus clock from initiator, pulled up externally.
- sda  inout  1  open-drain data; driven 0 or 'z only.
- reg_addr  out  16  current register pointer.
- reg_we  out  1  one-clk write strobe.
- reg_wdata  out  8  write data, valid while reg_we=1.
- reg_re  out  1  one-clk read request for reg_addr.
- reg_rdata  in  8  read data, sampled exactly 1 clk after reg_re.
- busy  out  1  high from addressed START to STOP / NACK-release.

Behaviour:
- Reset values: sda released ('z), reg_addr=0, reg_we=0, reg_wdata=0, reg_re=0, busy=0, state=IDLE. Async reset mid-transfer releases sda immediately.
- Input path: scl and sda pass through SyncStages flops. Edges are detected on the synchronized values: rise, fall, START (sda fall while scl high), STOP (sda rise while scl high).
- Bit timing: sda is sampled on each scl rise. The drive value changes only on scl fall, never while scl is high.
- START (including repeated START) from any state: go to DEV, clear the bit counter, release sda. reg_addr is kept.
- STOP from any state: go to IDLE, release sda, busy=0. No strobe is issued for a partial byte.
- States: IDLE, DEV, DEV_ACK, AHI, AHI_ACK, ALO, ALO_ACK, WDAT, WDAT_ACK, RDAT, RDAT_MACK, IGNORE.
- Byte shift: MSB first, with a 3-bit counter. The 8th sampled bit completes the byte.
- DEV: compare byte[7:1] with DevAddr[7:1].
  - Mismatch → IGNORE: never drive sda, no strobes, leave only on START or STOP.
  - Match → DEV_ACK, busy=1. Record R/W = byte[0].
- ACK drive: after a byte we own completes, pull sda low from the next scl fall through the following scl fall (9th clock). Then release, unless we are the read transmitter.
- Write path:
  - DEV(W) → AHI: byte becomes reg_addr[15:8]; then AHI_ACK.
  - ALO: byte becomes reg_addr[7:0]; then ALO_ACK.
  - Each subsequent WDAT byte: on the clk its 8th bit is sampled, pulse reg_we=1 for one clk with reg_wdata=byte and reg_addr unchanged. reg_addr increments (wrap FFFF→0000) the clk after the strobe. Then WDAT_ACK, then next WDAT.
- Read path:
  - DEV(R): on the clk the R/W bit is sampled, pulse reg_re. Capture reg_rdata 1 clk later into the shift register.
  - The first data bit is driven on the scl fall ending DEV_ACK.
  - RDAT: shift out 8 bits, release sda on the 8th-bit scl fall, then sample the initiator's ACK on the 9th rise.
  - ACK=0: increment reg_addr, pulse reg_re the same clk, reload, continue in RDAT.
  - NACK: go to IGNORE until STOP/START, busy=0.
- Combined transactions: a random read (write AHI/ALO, repeated START, DEV(R)) reads from the just-written pointer.
- reg_we and reg_re never assert in the same clk.

Test Plan:
- Write to 0x78: 78, 30, 08, 82, STOP → ACK low on 4 ninth-clocks; single reg_we with reg_addr=16'h3008, reg_wdata=8'h82; reg_addr=16'h3009 afterward.
- Address 0x42 write, 3 bytes → sda never low from target, no reg_we, busy stays 0.
- Burst write of 11, 22, 33 at 0x4300 → three reg_we at addresses 4300/4301/4302 with the matching data.
- Random read: 78, 30, 0A, Sr, 79; model returns 8'h56 then 8'hA5; initiator ACKs then NACKs → sda bits 01010110 then 10100101; reg_re at 300A and 300B; sda released after NACK.
- STOP after 5 bits of a data byte → IDLE, no reg_we, reg_addr unchanged; the next full write succeeds.
- rst_n low during an ACK (sda held low) → sda 'z within the same clk, all outputs at reset values; the following START/address is ACKed.
